// File: rtl/cmd_cntrl_route.sv
// Command controller for the follower robot: queues destination station IDs,
// sequences MOVE/DWELL between stops and drives the obstacle buzzer.
module cmd_cntrl_route #(
    parameter int ID_W      = 6,
    parameter int QDEPTH    = 4,
    parameter int DWELL_CYC = 25000000,
    parameter int BUZZ_HALF = 6250
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   cmd,
    input  logic                         cmd_rdy,
    output logic                         clr_cmd_rdy,
    input  logic [7:0]                   ID,
    input  logic                         ID_vld,
    output logic                         clr_ID_vld,
    input  logic                         OK2Move,
    output logic                         in_transit,
    output logic                         go,
    output logic                         buzz,
    output logic                         buzz_n,
    output logic [ID_W-1:0]              dest_ID,
    output logic [$clog2(QDEPTH+1)-1:0]  q_cnt,
    output logic                         q_ovf
);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int DW_W  = $clog2(DWELL_CYC + 1);
    localparam int BZ_W  = $clog2(BUZZ_HALF + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, MOVE = 2'b01, DWELL = 2'b10} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   mem_q [QDEPTH];
    logic [ID_W-1:0]   mem_d [QDEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [BZ_W-1:0]   bz_cnt_q, bz_cnt_d;
    logic [ID_W-1:0]   dest_q, dest_d;
    logic              in_transit_q, in_transit_d;
    logic              buzz_q, buzz_d;
    logic              ovf_q, ovf_d;
    logic [ID_W-1:0]   cmd_id_s;
    logic              buzz_active_s;

    assign cmd_id_s = cmd[ID_W-1:0];

    // Next-state for the route FSM and destination queue; commands override ID handling.
    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
        ovf_d       = 1'b0;
        clr_cmd_rdy = cmd_rdy;
        clr_ID_vld  = ID_vld & ~cmd_rdy;

        case (state_q)
            MOVE: begin
                if (ID_vld && !cmd_rdy && (ID == 8'(dest_q))) begin
                    rd_d  = rd_q + PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DWELL;
                        dwell_d = DW_W'(DWELL_CYC - 1);
                    end
                end else begin
                    state_d = MOVE;
                end
            end
            DWELL: begin
                if (dwell_q == {DW_W{1'b0}}) begin
                    state_d = MOVE;
                end else begin
                    dwell_d = dwell_q - DW_W'(1);
                end
            end
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (cmd_rdy) begin
            case (cmd[7:6])
                2'b00: begin
                    rd_d    = {PTR_W{1'b0}};
                    wr_d    = {PTR_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    dwell_d = {DW_W{1'b0}};
                    state_d = IDLE;
                end
                2'b01: begin
                    mem_d[0] = cmd_id_s;
                    rd_d     = {PTR_W{1'b0}};
                    wr_d     = PTR_W'(1);
                    cnt_d    = CNT_W'(1);
                    state_d  = MOVE;
                end
                2'b10: begin
                    if (cnt_q == CNT_W'(QDEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_d[wr_q] = cmd_id_s;
                        wr_d        = wr_q + PTR_W'(1);
                        cnt_d       = cnt_q + CNT_W'(1);
                        if (state_q == IDLE) begin
                            state_d = MOVE;
                        end else begin
                            state_d = state_d;
                        end
                    end
                end
                default: state_d = state_d;
            endcase
        end else begin
            ovf_d = 1'b0;
        end

        in_transit_d = (state_d == MOVE);
        if (cnt_d != {CNT_W{1'b0}}) begin
            dest_d = mem_d[rd_d];
        end else begin
            dest_d = {ID_W{1'b0}};
        end
    end

    // Buzzer half-period counter; a square wave starting low while blocked in transit.
    always_comb begin
        buzz_active_s = in_transit_q & ~OK2Move;
        bz_cnt_d      = {BZ_W{1'b0}};
        buzz_d        = 1'b0;
        if (buzz_active_s) begin
            if (bz_cnt_q == BZ_W'(BUZZ_HALF - 1)) begin
                bz_cnt_d = {BZ_W{1'b0}};
                buzz_d   = ~buzz_q;
            end else begin
                bz_cnt_d = bz_cnt_q + BZ_W'(1);
                buzz_d   = buzz_q;
            end
        end else begin
            bz_cnt_d = {BZ_W{1'b0}};
            buzz_d   = 1'b0;
        end
    end

    // State, queue and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= {ID_W{1'b0}};
            end
            rd_q         <= {PTR_W{1'b0}};
            wr_q         <= {PTR_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            dwell_q      <= {DW_W{1'b0}};
            bz_cnt_q     <= {BZ_W{1'b0}};
            dest_q       <= {ID_W{1'b0}};
            in_transit_q <= 1'b0;
            buzz_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            bz_cnt_q     <= bz_cnt_d;
            dest_q       <= dest_d;
            in_transit_q <= in_transit_d;
            buzz_q       <= buzz_d;
            ovf_q        <= ovf_d;
        end
    end

    assign in_transit = in_transit_q;
    assign go         = in_transit_q & OK2Move;
    assign buzz       = buzz_q;
    assign buzz_n     = ~buzz_q;
    assign dest_ID    = dest_q;
    assign q_cnt      = cnt_q;
    assign q_ovf      = ovf_q;
endmodule

// File: tb/tb_cmd_cntrl_route.sv
// Directed bench for cmd_cntrl_route with a short dwell and buzz period.
module tb_cmd_cntrl_route;
    localparam int ID_W      = 6;
    localparam int QDEPTH    = 4;
    localparam int DWELL_CYC = 20;
    localparam int BUZZ_HALF = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic        cmd_rdy = 1'b0;
    logic        clr_cmd_rdy;
    logic [7:0]  ID = 8'h00;
    logic        ID_vld = 1'b0;
    logic        clr_ID_vld;
    logic        OK2Move = 1'b1;
    logic        in_transit, go, buzz, buzz_n, q_ovf;
    logic [ID_W-1:0] dest_ID;
    logic [2:0]  q_cnt;

    int total = 0;
    int bad = 0;
    logic clr_cmd_seen, clr_id_seen;

    cmd_cntrl_route #(.ID_W(ID_W), .QDEPTH(QDEPTH), .DWELL_CYC(DWELL_CYC), .BUZZ_HALF(BUZZ_HALF)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move),
        .in_transit(in_transit), .go(go), .buzz(buzz), .buzz_n(buzz_n),
        .dest_ID(dest_ID), .q_cnt(q_cnt), .q_ovf(q_ovf)
    );

    always #5 clk = ~clk;

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk);
        cmd = c;
        cmd_rdy = 1'b1;
        #1;
        clr_cmd_seen = clr_cmd_rdy;
        @(negedge clk);
        cmd_rdy = 1'b0;
    endtask

    task automatic send_id(input logic [7:0] v);
        @(negedge clk);
        ID = v;
        ID_vld = 1'b1;
        #1;
        clr_id_seen = clr_ID_vld;
        @(negedge clk);
        ID_vld = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({in_transit, go, buzz, buzz_n, q_ovf, clr_cmd_rdy, clr_ID_vld} !== 7'b0001000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0001000",
                     {in_transit, go, buzz, buzz_n, q_ovf, clr_cmd_rdy, clr_ID_vld});
        end
        total++;
        if (dest_ID !== 6'd0 || q_cnt !== 3'd0) begin
            bad++;
            $display("FAIL reset_queue got dest=%0d cnt=%0d want 0 0", dest_ID, q_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_go;
        send_cmd(8'h45);
        total++;
        if (clr_cmd_seen !== 1'b1) begin bad++; $display("FAIL go_clr got=%b want=1", clr_cmd_seen); end
        total++;
        if (in_transit !== 1'b1 || go !== 1'b1 || dest_ID !== 6'd5 || q_cnt !== 3'd1) begin
            bad++;
            $display("FAIL go_state got it=%b go=%b dest=%0d cnt=%0d want 1 1 5 1", in_transit, go, dest_ID, q_cnt);
        end
        send_id(8'h05);
        total++;
        if (clr_id_seen !== 1'b1) begin bad++; $display("FAIL go_clr_id got=%b want=1", clr_id_seen); end
        total++;
        if (in_transit !== 1'b0 || q_cnt !== 3'd0 || dest_ID !== 6'd0) begin
            bad++;
            $display("FAIL go_arrive got it=%b cnt=%0d dest=%0d want 0 0 0", in_transit, q_cnt, dest_ID);
        end
    endtask

    task automatic test_dwell;
        int n;
        send_cmd(8'h43);
        send_cmd(8'h87);
        send_cmd(8'h89);
        total++;
        if (q_cnt !== 3'd3 || dest_ID !== 6'd3) begin
            bad++;
            $display("FAIL dwell_fill got cnt=%0d dest=%0d want 3 3", q_cnt, dest_ID);
        end
        send_id(8'h03);
        total++;
        if (in_transit !== 1'b0 || q_cnt !== 3'd2 || dest_ID !== 6'd7) begin
            bad++;
            $display("FAIL dwell_pop got it=%b cnt=%0d dest=%0d want 0 2 7", in_transit, q_cnt, dest_ID);
        end
        for (int k = 1; k < DWELL_CYC; k++) begin
            @(negedge clk);
            total++;
            if (in_transit !== 1'b0) begin bad++; $display("FAIL dwell_early cyc=%0d got=1 want=0", k); end
        end
        @(negedge clk);
        total++;
        if (in_transit !== 1'b1 || dest_ID !== 6'd7) begin
            bad++;
            $display("FAIL dwell_resume got it=%b dest=%0d want 1 7", in_transit, dest_ID);
        end
        send_id(8'h07);
        n = 0;
        while (in_transit !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        total++;
        if (in_transit !== 1'b1 || dest_ID !== 6'd9) begin
            bad++;
            $display("FAIL dwell_second got it=%b dest=%0d want 1 9", in_transit, dest_ID);
        end
        send_id(8'h09);
        total++;
        if (in_transit !== 1'b0 || q_cnt !== 3'd0) begin
            bad++;
            $display("FAIL dwell_idle got it=%b cnt=%0d want 0 0", in_transit, q_cnt);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] seq [4];
        int n;
        seq[0] = 8'h02; seq[1] = 8'h03; seq[2] = 8'h04; seq[3] = 8'h06;
        send_cmd(8'h81);
        send_cmd(8'h82);
        send_cmd(8'h83);
        send_cmd(8'h84);
        total++;
        if (q_cnt !== 3'd4 || q_ovf !== 1'b0 || in_transit !== 1'b1 || dest_ID !== 6'd1) begin
            bad++;
            $display("FAIL ovf_fill got cnt=%0d ovf=%b it=%b dest=%0d want 4 0 1 1", q_cnt, q_ovf, in_transit, dest_ID);
        end
        send_cmd(8'h85);
        total++;
        if (clr_cmd_seen !== 1'b1 || q_ovf !== 1'b1 || q_cnt !== 3'd4) begin
            bad++;
            $display("FAIL ovf_pulse got clr=%b ovf=%b cnt=%0d want 1 1 4", clr_cmd_seen, q_ovf, q_cnt);
        end
        @(negedge clk);
        total++;
        if (q_ovf !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle got=1 want=0"); end
        send_id(8'h01);
        send_cmd(8'h86);
        total++;
        if (q_cnt !== 3'd4 || in_transit !== 1'b0 || dest_ID !== 6'd2) begin
            bad++;
            $display("FAIL ovf_append_dwell got cnt=%0d it=%b dest=%0d want 4 0 2", q_cnt, in_transit, dest_ID);
        end
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (in_transit !== 1'b1 && n < 40) begin @(negedge clk); n++; end
            total++;
            if (in_transit !== 1'b1 || 8'(dest_ID) !== seq[i]) begin
                bad++;
                $display("FAIL wrap_head i=%0d got it=%b dest=%0d want 1 %0d", i, in_transit, dest_ID, seq[i]);
            end
            send_id(seq[i]);
        end
        total++;
        if (q_cnt !== 3'd0 || in_transit !== 1'b0) begin
            bad++;
            $display("FAIL wrap_drain got cnt=%0d it=%b want 0 0", q_cnt, in_transit);
        end
    endtask

    task automatic test_mismatch;
        send_cmd(8'h45);
        send_id(8'h02);
        total++;
        if (clr_id_seen !== 1'b1 || in_transit !== 1'b1 || q_cnt !== 3'd1 || dest_ID !== 6'd5) begin
            bad++;
            $display("FAIL mismatch got clr=%b it=%b cnt=%0d dest=%0d want 1 1 1 5", clr_id_seen, in_transit, q_cnt, dest_ID);
        end
    endtask

    task automatic test_priority;
        @(negedge clk);
        cmd = 8'h00; cmd_rdy = 1'b1; ID = 8'h05; ID_vld = 1'b1;
        #1;
        total++;
        if (clr_cmd_rdy !== 1'b1 || clr_ID_vld !== 1'b0) begin
            bad++;
            $display("FAIL prio_same_cycle got clr_cmd=%b clr_id=%b want 1 0", clr_cmd_rdy, clr_ID_vld);
        end
        @(negedge clk);
        cmd_rdy = 1'b0;
        #1;
        total++;
        if (q_cnt !== 3'd0 || in_transit !== 1'b0 || dest_ID !== 6'd0 || clr_ID_vld !== 1'b1) begin
            bad++;
            $display("FAIL prio_flush got cnt=%0d it=%b dest=%0d clr_id=%b want 0 0 0 1", q_cnt, in_transit, dest_ID, clr_ID_vld);
        end
        @(negedge clk);
        ID_vld = 1'b0;
        total++;
        if (q_cnt !== 3'd0 || in_transit !== 1'b0) begin
            bad++;
            $display("FAIL prio_no_pop got cnt=%0d it=%b want 0 0", q_cnt, in_transit);
        end
    endtask

    task automatic test_buzz;
        logic exp_b;
        send_cmd(8'h4A);
        @(negedge clk);
        OK2Move = 1'b0;
        #1;
        total++;
        if (go !== 1'b0 || in_transit !== 1'b1) begin bad++; $display("FAIL buzz_go_low got go=%b it=%b want 0 1", go, in_transit); end
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            exp_b = ((k / BUZZ_HALF) % 2) == 1;
            total++;
            if (buzz !== exp_b || buzz_n !== ~exp_b) begin
                bad++;
                $display("FAIL buzz_wave cyc=%0d got buzz=%b buzz_n=%b want %b", k, buzz, buzz_n, exp_b);
            end
        end
        OK2Move = 1'b1;
        #1;
        total++;
        if (go !== 1'b1) begin bad++; $display("FAIL buzz_go_high got=%b want=1", go); end
        @(negedge clk);
        total++;
        if (buzz !== 1'b0 || buzz_n !== 1'b1) begin bad++; $display("FAIL buzz_clear got=%b want=0", buzz); end
        OK2Move = 1'b0;
        for (int k = 1; k <= BUZZ_HALF; k++) begin
            @(negedge clk);
            total++;
            if (buzz !== (k == BUZZ_HALF)) begin
                bad++;
                $display("FAIL buzz_restart cyc=%0d got=%b want=%b", k, buzz, (k == BUZZ_HALF));
            end
        end
        OK2Move = 1'b1;
        send_cmd(8'h00);
    endtask

    task automatic test_reset_midmove;
        send_cmd(8'h4C);
        send_cmd(8'h8D);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_transit !== 1'b0 || q_cnt !== 3'd0 || dest_ID !== 6'd0) begin
            bad++;
            $display("FAIL reset_abort got it=%b cnt=%0d dest=%0d want 0 0 0", in_transit, q_cnt, dest_ID);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_transit !== 1'b0 || q_cnt !== 3'd0) begin
            bad++;
            $display("FAIL reset_release got it=%b cnt=%0d want 0 0", in_transit, q_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_go;
        test_dwell;
        test_overflow;
        test_mismatch;
        test_priority;
        test_buzz;
        test_reset_midmove;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmd_cntrl_route.md
Name: cmd_cntrl_route

Overview:
Next-generation command controller for the follower robot. It accepts 8-bit commands from the UART/BLE command path and holds a queue of up to QDEPTH destination station IDs. It drives the robot from station to station, pausing for a programmable dwell time at each intermediate stop. It gates motion with the proximity sensor (go) and drives a differential piezo buzzer when an obstacle blocks a move.

Parameters:
ID_W, 6, width of destination ID carried in cmd[ID_W-1:0] (ID_W <= 6)
QDEPTH, 4, destination queue depth (power of 2, >= 2)
DWELL_CYC, 25000000, clk cycles spent stopped at an intermediate station (0.5 s @ 50 MHz)
BUZZ_HALF, 6250, clk cycles per buzz half-period (4 kHz @ 50 MHz)

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  asynchronous active-low reset
cmd  in  8  command byte; [7:6] opcode, [ID_W-1:0] station ID
cmd_rdy  in  1  cmd valid, held until cleared
clr_cmd_rdy  out  1  one-cycle pulse consuming cmd
ID  in  8  station ID read by the barcode reader
ID_vld  in  1  ID valid, held until cleared
clr_ID_vld  out  1  one-cycle pulse consuming ID
OK2Move  in  1  low = obstacle present
in_transit  out  1  robot is travelling toward the queue head
go  out  1  in_transit & OK2Move (combinational)
buzz  out  1  piezo drive, registered
buzz_n  out  1  ~buzz (combinational)
dest_ID  out  ID_W  queue head; 0 when the queue is empty
q_cnt  out  $clog2(QDEPTH+1)  number of queued destinations
q_ovf  out  1  one-cycle pulse when an APPEND is dropped because the queue is full

Behaviour:
- Reset: state=IDLE, queue empty, q_cnt=0, dest_ID=0, in_transit=0, buzz=0, q_ovf=0, dwell/buzz counters cleared. Reset mid-move aborts immediately, with no pending pops.
- clr_cmd_rdy and clr_ID_vld are combinational Mealy outputs of the FSM. Every other output is registered, except go and buzz_n.
- Opcodes (cmd[7:6]):
  - 00 STOP: flush the queue, go to IDLE.
  - 01 GO: flush the queue, push cmd ID, go to MOVE.
  - 10 APPEND: push cmd ID. If IDLE, go to MOVE. If the queue is full, drop the ID and pulse q_ovf.
  - 11: reserved, consumed with no effect.
- Every command is consumed: clr_cmd_rdy=1 in the same cycle cmd_rdy is seen high, in any state.
- FSM states: IDLE, MOVE, DWELL. in_transit=1 exactly when state==MOVE (registered with the state).
- MOVE, when ID_vld=1 and cmd_rdy=0:
  - Always assert clr_ID_vld.
  - If ID == zero-extended dest_ID, pop the head. If q_cnt becomes 0, go to IDLE; otherwise go to DWELL and load the dwell counter with DWELL_CYC-1.
  - On mismatch, the ID is consumed with no other effect.
- IDLE or DWELL, when ID_vld=1 and cmd_rdy=0: clr_ID_vld only, no state change.
- Priority: cmd_rdy beats ID_vld in the same cycle. ID_vld is not cleared that cycle and is evaluated on the next cycle against the updated queue.
- DWELL: the counter decrements each cycle. At 0, go to MOVE toward the new head, so in_transit rises DWELL_CYC cycles after the pop. A STOP/GO/APPEND during DWELL takes effect immediately: STOP goes to IDLE, GO goes to MOVE, APPEND pushes and stays in DWELL.
- Queue: circular buffer with read/write pointers and a count.
  - Push and pop in the same cycle cannot occur, because command priority excludes it.
  - GO's flush+push leaves q_cnt=1.
  - Pointers wrap modulo QDEPTH.
- Buzzer: active when in_transit & ~OK2Move.
  - While active, the counter counts 0..BUZZ_HALF-1 and buzz toggles on wrap, giving a 50% duty square wave that starts low.
  - When inactive, the counter clears and buzz is forced to 0 on the next clk.

Test Plan:
- Reset, then GO cmd=8'h45 -> clr_cmd_rdy pulse, in_transit=1 next cycle, dest_ID=5, q_cnt=1. ID=8'h05 with ID_vld -> clr_ID_vld, in_transit=0, q_cnt=0, IDLE.
- GO 8'h43, APPEND 8'h87, APPEND 8'h89 -> q_cnt=3. ID 3 -> DWELL. in_transit returns exactly DWELL_CYC cycles later (use DWELL_CYC=20), dest_ID=7. ID 7, then ID 9 -> IDLE.
- APPEND 5 times with QDEPTH=4 -> 5th gives q_ovf pulse, q_cnt=4, clr_cmd_rdy still pulses.
- In MOVE with head=5, ID 8'h02 -> clr_ID_vld only, in_transit stays 1, q_cnt unchanged.
- cmd_rdy and ID_vld (matching) high in the same cycle with STOP -> queue flushed, IDLE, clr_ID_vld=0 that cycle, ID consumed with no pop next cycle.
- MOVE with OK2Move=0 for 40 cycles, BUZZ_HALF=5 -> go=0, buzz toggles every 5 cycles, buzz_n=~buzz. OK2Move=1 -> buzz=0 next clk, go=1.
